// File: rtl/learn_sched_pkg.sv
// Shared sizing defaults and FSM state encoding for the learnCosts scheduler.
package learn_sched_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/learn_sched_if.sv
// Packet ingress and learnCosts handshake bundle; slave is the scheduler side.
interface learn_sched_if #(
  parameter int unsigned WORD_WIDTH = learn_sched_pkg::WORD_WIDTH
);

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [WORD_WIDTH-1:0] pkt_sourceID;
  logic [WORD_WIDTH-1:0] pkt_batteryStat;
  logic [WORD_WIDTH-1:0] pkt_value;
  logic [WORD_WIDTH-1:0] pkt_clusterID;

  logic                  lc_en;
  logic [WORD_WIDTH-1:0] lc_fsourceID;
  logic [WORD_WIDTH-1:0] lc_fbatteryStat;
  logic [WORD_WIDTH-1:0] lc_fValue;
  logic [WORD_WIDTH-1:0] lc_fclusterID;
  logic                  lc_done;
  logic                  lc_reinit;

  modport master (
    output pkt_valid, pkt_sourceID, pkt_batteryStat, pkt_value, pkt_clusterID,
    output lc_done, lc_reinit,
    input  pkt_ready, lc_en, lc_fsourceID, lc_fbatteryStat, lc_fValue, lc_fclusterID
  );

  modport slave (
    input  pkt_valid, pkt_sourceID, pkt_batteryStat, pkt_value, pkt_clusterID,
    input  lc_done, lc_reinit,
    output pkt_ready, lc_en, lc_fsourceID, lc_fbatteryStat, lc_fValue, lc_fclusterID
  );

endinterface

// File: rtl/learn_sched_pkt_fifo.sv
// Packet buffer holding the four packed fields; pointers wrap modulo DEPTH.
module pkt_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop_ok)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/learn_sched.sv
// Buffers neighbour packets and feeds them one at a time to learnCosts,
// tracking completions, re-init requests and per-job timeouts.
module learn_sched #(
  parameter int unsigned WORD_WIDTH = learn_sched_pkg::WORD_WIDTH,
  parameter int unsigned FIFO_DEPTH = learn_sched_pkg::FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = learn_sched_pkg::TIMEOUT
) (
  input  logic                         clock,
  input  logic                         nrst,
  learn_sched_if.slave                 sched_bus,
  output logic                         reinit_req,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [7:0]                   done_cnt,
  output logic                         timeout_err
);

  import learn_sched_pkg::*;

  localparam int unsigned PW = 4 * WORD_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [PW-1:0]   wdata;
  logic [PW-1:0]   rdata;
  logic [PW-1:0]   lc_fields;
  logic            lc_en_q;
  logic            full;
  logic            empty;
  logic            pop;

  assign wdata = {sched_bus.pkt_sourceID, sched_bus.pkt_batteryStat,
                  sched_bus.pkt_value, sched_bus.pkt_clusterID};

  // Ready comes from the registered count only, so a pop while full frees
  // the slot for the following cycle, never the current one.
  assign sched_bus.pkt_ready = ~full;
  assign pop = (state == ST_IDLE) & ~empty;

  assign sched_bus.lc_en = lc_en_q;
  assign {sched_bus.lc_fsourceID, sched_bus.lc_fbatteryStat,
          sched_bus.lc_fValue, sched_bus.lc_fclusterID} = lc_fields;

  pkt_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_pkt_fifo (
    .clock (clock),
    .nrst  (nrst),
    .push  (sched_bus.pkt_valid),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      lc_fields   <= '0;
      lc_en_q     <= 1'b0;
      reinit_req  <= 1'b0;
      busy        <= 1'b0;
      done_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      lc_en_q    <= 1'b0;
      reinit_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            lc_fields <= rdata;
            lc_en_q   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sched_bus.lc_done) begin
            done_cnt   <= done_cnt + 8'd1;
            reinit_req <= sched_bus.lc_reinit;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_learn_sched.sv
// Scoreboard bench for learn_sched: expected packets queue on acceptance and
// are matched against the lc_* fields at every lc_en pulse.
module tb_learn_sched;

  localparam int unsigned W   = 16;
  localparam int unsigned DEP = 4;
  localparam int unsigned TMO = 8;
  localparam int unsigned PW  = 4 * W;

  logic       clock = 1'b0;
  logic       nrst  = 1'b0;
  logic       reinit_req;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] done_cnt;
  logic       timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int launches    = 0;
  int handled     = 0;

  logic [PW-1:0] exp_q[$];
  logic          prev_en = 1'b0;

  always #5 clock = ~clock;

  learn_sched_if #(.WORD_WIDTH(W)) bus ();

  learn_sched #(
    .WORD_WIDTH (W),
    .FIFO_DEPTH (DEP),
    .TIMEOUT    (TMO)
  ) dut (
    .clock       (clock),
    .nrst        (nrst),
    .sched_bus   (bus.slave),
    .reinit_req  (reinit_req),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .done_cnt    (done_cnt),
    .timeout_err (timeout_err)
  );

  // Launch monitor: samples shortly after each rising edge.
  always begin
    logic [PW-1:0] got;
    logic [PW-1:0] want;
    @(posedge clock);
    #2;
    got = {bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID};
    if (nrst && bus.lc_en) begin
      launches++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_launch got fields %h with nothing queued", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL launch_fields got %h want %h", got, want);
        end
      end
      vectors++;
      if (prev_en) begin
        miscompares++;
        $display("FAIL lc_en_width got 2+ cycles want 1");
      end
    end
    prev_en = nrst ? bus.lc_en : 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send_pkt(input logic [PW-1:0] p);
    int unsigned n;
    n = 0;
    {bus.pkt_sourceID, bus.pkt_batteryStat, bus.pkt_value, bus.pkt_clusterID} = p;
    bus.pkt_valid = 1'b1;
    while (!bus.pkt_ready && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (!bus.pkt_ready) begin
      miscompares++;
      $display("FAIL send_ready got 0 want 1 within 50 cycles");
    end else begin
      exp_q.push_back(p);
    end
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_launch();
    int unsigned n;
    n = 0;
    while (launches <= handled && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (launches <= handled) begin
      miscompares++;
      $display("FAIL wait_launch got %0d launches want %0d", launches, handled + 1);
    end
    handled++;
  endtask

  task automatic finish_job();
    wait_launch();
    tick();
    tick();
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    #1;
    vectors++; if (bus.pkt_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", bus.pkt_ready); end
    vectors++; if (bus.lc_en !== 1'b0) begin miscompares++; $display("FAIL rst_lc_en got %b want 0", bus.lc_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    vectors++; if (done_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_done got %0d want 0", done_cnt); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_tmo got %b want 0", timeout_err); end
    vectors++; if (reinit_req !== 1'b0) begin miscompares++; $display("FAIL rst_reinit got %b want 0", reinit_req); end
    vectors++;
    if ({bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID} !== '0) begin
      miscompares++;
      $display("FAIL rst_fields got %h want 0", {bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID});
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    p = {16'd31, 16'd5, 16'd10, 16'd11};
    {bus.pkt_sourceID, bus.pkt_batteryStat, bus.pkt_value, bus.pkt_clusterID} = p;
    bus.pkt_valid = 1'b1;
    exp_q.push_back(p);
    tick();
    bus.pkt_valid = 1'b0;
    vectors++; if (bus.lc_en !== 1'b0) begin miscompares++; $display("FAIL single_early_en got %b want 0", bus.lc_en); end
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", fifo_count); end
    tick();
    vectors++; if (bus.lc_en !== 1'b1) begin miscompares++; $display("FAIL single_en got %b want 1", bus.lc_en); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", busy); end
    vectors++;
    if ({bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID} !== p) begin
      miscompares++;
      $display("FAIL single_fields got %h want %h", {bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID}, p);
    end
    handled++;
    tick();
    vectors++; if (bus.lc_en !== 1'b0) begin miscompares++; $display("FAIL single_en_width got %b want 0", bus.lc_en); end
    tick();
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done = 1'b0;
    vectors++; if (done_cnt !== 8'd1) begin miscompares++; $display("FAIL single_done got %0d want 1", done_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b want 0", busy); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) send_pkt({4{16'(i)}});
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d want 4", fifo_count); end
    vectors++; if (bus.pkt_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", bus.pkt_ready); end
    {bus.pkt_sourceID, bus.pkt_batteryStat, bus.pkt_value, bus.pkt_clusterID} = {4{16'd6}};
    bus.pkt_valid = 1'b1;
    repeat (3) tick();
    bus.pkt_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fill_holdoff got %0d want 4", fifo_count); end
    repeat (5) finish_job();
    tick();
    vectors++; if (done_cnt !== 8'd6) begin miscompares++; $display("FAIL fill_done got %0d want 6", done_cnt); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL fill_drain got %0d want 0", fifo_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fill_busy got %b want 0", busy); end
  endtask

  task automatic test_reinit();
    send_pkt({16'hA1, 16'hA2, 16'hA3, 16'hA4});
    wait_launch();
    tick();
    tick();
    bus.lc_reinit = 1'b1;
    repeat (2) begin
      tick();
      vectors++; if (reinit_req !== 1'b0) begin miscompares++; $display("FAIL reinit_alone got %b want 0", reinit_req); end
    end
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done   = 1'b0;
    bus.lc_reinit = 1'b0;
    vectors++; if (reinit_req !== 1'b1) begin miscompares++; $display("FAIL reinit_pulse got %b want 1", reinit_req); end
    vectors++; if (done_cnt !== 8'd7) begin miscompares++; $display("FAIL reinit_done got %0d want 7", done_cnt); end
    tick();
    vectors++; if (reinit_req !== 1'b0) begin miscompares++; $display("FAIL reinit_width got %b want 0", reinit_req); end
    bus.lc_done   = 1'b1;
    bus.lc_reinit = 1'b1;
    tick();
    bus.lc_done   = 1'b0;
    bus.lc_reinit = 1'b0;
    tick();
    vectors++; if (done_cnt !== 8'd7) begin miscompares++; $display("FAIL idle_done_ignored got %0d want 7", done_cnt); end
    vectors++; if (reinit_req !== 1'b0) begin miscompares++; $display("FAIL idle_reinit got %b want 0", reinit_req); end
  endtask

  task automatic test_timeout();
    send_pkt({16'hB1, 16'hB2, 16'hB3, 16'hB4});
    wait_launch();
    repeat (TMO) tick();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", timeout_err); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tmo_busy got %b want 1", busy); end
    tick();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_flag got %b want 1", timeout_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle got %b want 0", busy); end
    vectors++; if (done_cnt !== 8'd7) begin miscompares++; $display("FAIL tmo_done got %0d want 7", done_cnt); end
    send_pkt({16'hC1, 16'hC2, 16'hC3, 16'hC4});
    finish_job();
    vectors++; if (done_cnt !== 8'd8) begin miscompares++; $display("FAIL tmo_next_done got %0d want 8", done_cnt); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    send_pkt({16'hD1, 16'hD2, 16'hD3, 16'hD4});
    wait_launch();
    send_pkt({16'hE1, 16'hE2, 16'hE3, 16'hE4});
    send_pkt({16'hF1, 16'hF2, 16'hF3, 16'hF4});
    vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL mid_queued got %0d want 2", fifo_count); end
    nrst = 1'b0;
    #1;
    exp_q.delete();
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
    vectors++; if (done_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_done got %0d want 0", done_cnt); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL mid_tmo got %b want 0", timeout_err); end
    vectors++; if (bus.pkt_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", bus.pkt_ready); end
    vectors++;
    if ({bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID} !== '0) begin
      miscompares++;
      $display("FAIL mid_fields got %h want 0", {bus.lc_fsourceID, bus.lc_fbatteryStat, bus.lc_fValue, bus.lc_fclusterID});
    end
    tick();
    tick();
    nrst = 1'b1;
    repeat (6) tick();
    vectors++; if (launches !== handled) begin miscompares++; $display("FAIL mid_no_launch got %0d launches want %0d", launches, handled); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_release_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 65; b++) begin
      for (int k = 0; k < 4; k++) send_pkt({$urandom, $urandom});
      for (int k = 0; k < 4; k++) finish_job();
    end
    tick();
    vectors++; if (done_cnt !== 8'd4) begin miscompares++; $display("FAIL wrap_done got %0d want 4", done_cnt); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL wrap_count got %0d want 0", fifo_count); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL wrap_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    bus.pkt_valid       = 1'b0;
    bus.pkt_sourceID    = '0;
    bus.pkt_batteryStat = '0;
    bus.pkt_value       = '0;
    bus.pkt_clusterID   = '0;
    bus.lc_done         = 1'b0;
    bus.lc_reinit       = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_reinit();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
